// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 microsequencer: microword field positions,
// COND branch encodings and the run/halt state type.
package lc3_pkg;

   localparam int UINSTR_W  = 49;
   localparam int IRD_BIT   = 48;
   localparam int COND_HI   = 47;
   localparam int COND_LO   = 45;
   localparam int J_HI      = 44;
   localparam int J_LO      = 39;
   localparam int J_W       = J_HI - J_LO + 1;
   localparam int UPC_FETCH = 18;

   typedef enum logic [2:0] {
      COND_NONE   = 3'b000,
      COND_READY  = 3'b001,
      COND_BRANCH = 3'b010,
      COND_ADDR   = 3'b011,
      COND_INT    = 3'b101
   } cond_e;

   typedef enum logic {
      S_RUN    = 1'b0,
      S_HALTED = 1'b1
   } seq_state_e;

endpackage

// File: rtl/lc3_upc_next.sv
// Combinational next-microaddress selection: IRD dispatch or J with the
// COND-selected status bit ORed into its slot.
module lc3_upc_next
   import lc3_pkg::*;
#(
   parameter int UPC_W = 6
) (
   input  logic             ird,
   input  logic [2:0]       cond,
   input  logic [J_W-1:0]   j,
   input  logic             ben,
   input  logic             r,
   input  logic [3:0]       ir_op,
   input  logic             ir_11,
   input  logic             int_req,
   output logic [UPC_W-1:0] next
);

   logic [UPC_W-1:0] j_ext;

   assign j_ext = UPC_W'(j);

   // Status bits are ORed into J, never added, so no carry can ripple.
   always_comb begin
      next = j_ext;
      if (ird) begin
         next = UPC_W'(ir_op);
      end else begin
         case (cond)
            COND_READY:  next = j_ext | (UPC_W'(r)       << 1);
            COND_BRANCH: next = j_ext | (UPC_W'(ben)     << 2);
            COND_ADDR:   next = j_ext |  UPC_W'(ir_11);
            COND_INT:    next = j_ext | (UPC_W'(int_req) << 3);
            default:     next = j_ext;
         endcase
      end
   end

endmodule

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: uPC register, run/halt handshake, retired-instruction
// counter. Optional memory-timeout fault path enabled by LC3_MEM_TIMEOUT_EN.
//
// state    | meaning
// S_RUN    | uPC advances every cycle; halts at the next fetch boundary if run=0
// S_HALTED | uPC parked at FETCH_UPC, counters frozen, waiting for run=1
module lc3_microsequencer
   import lc3_pkg::*;
#(
   parameter int UPC_W     = 6,
   parameter int FETCH_UPC = UPC_FETCH,
   parameter int FAULT_UPC = 63,
   parameter int TIMEOUT   = 255,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [UINSTR_W-1:0] uinstruction,
   input  logic                ben,
   input  logic                r,
   input  logic [15:0]         ir,
   input  logic                int_req,
   input  logic                run,
   output logic [UPC_W-1:0]    upc,
   output logic                halted,
   output logic [CNT_W-1:0]    instr_count,
   output logic                mem_fault
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("lc3_microsequencer: TIMEOUT must be at least 1");
   end

   seq_state_e       state;
   logic             ird;
   logic [2:0]       cond;
   logic [UPC_W-1:0] next;
   logic             fault_hit;
   logic             unused_bits;

   assign ird         = uinstruction[IRD_BIT];
   assign cond        = uinstruction[COND_HI:COND_LO];
   assign unused_bits = ^{uinstruction[J_LO-1:0], ir[10:0]};

   lc3_upc_next #(.UPC_W(UPC_W)) u_next (
      .ird     (ird),
      .cond    (cond),
      .j       (uinstruction[J_HI:J_LO]),
      .ben     (ben),
      .r       (r),
      .ir_op   (ir[15:12]),
      .ir_11   (ir[11]),
      .int_req (int_req),
      .next    (next)
   );

`ifdef LC3_MEM_TIMEOUT_EN
   localparam int SC_W = $clog2(TIMEOUT + 1);

   logic [SC_W-1:0] stall_cnt;
   logic            stall;

   assign stall     = (cond == COND_READY) && !r;
   assign fault_hit = (state == S_RUN) && stall && (stall_cnt == SC_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         mem_fault <= 1'b0;
      end else if (state == S_RUN) begin
         if (fault_hit) begin
            stall_cnt <= '0;
            mem_fault <= 1'b1;
         end else if (stall) begin
            stall_cnt <= stall_cnt + 1'b1;
         end else begin
            stall_cnt <= '0;
         end
      end
   end
`else
   assign fault_hit = 1'b0;
   assign mem_fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_RUN;
         upc         <= UPC_W'(FETCH_UPC);
         halted      <= 1'b0;
         instr_count <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (ird) instr_count <= instr_count + 1'b1;
               if (fault_hit) begin
                  upc <= UPC_W'(FAULT_UPC);
               end else begin
                  upc <= next;
                  // Halting only on the fetch address keeps in-flight instructions intact.
                  if (!run && next == UPC_W'(FETCH_UPC)) begin
                     state  <= S_HALTED;
                     halted <= 1'b1;
                  end
               end
            end
            S_HALTED: begin
               if (run) begin
                  state  <= S_RUN;
                  halted <= 1'b0;
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Directed bench for lc3_microsequencer; covers the timeout path when
// LC3_MEM_TIMEOUT_EN is defined, otherwise checks an unbounded stall.
module tb_lc3_microsequencer;

`ifdef LC3_MEM_TIMEOUT_EN
   localparam int STALL_N = 3;
`else
   localparam int STALL_N = 5;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [48:0] uinstruction;
   logic        ben, r, int_req, run;
   logic [15:0] ir;
   logic [5:0]  upc;
   logic        halted;
   logic [15:0] instr_count;
   logic        mem_fault;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   lc3_microsequencer #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .uinstruction (uinstruction),
      .ben          (ben),
      .r            (r),
      .ir           (ir),
      .int_req      (int_req),
      .run          (run),
      .upc          (upc),
      .halted       (halted),
      .instr_count  (instr_count),
      .mem_fault    (mem_fault)
   );

   function automatic logic [48:0] w(input logic ird, input logic [2:0] cond, input logic [5:0] j);
      return {ird, cond, j, 39'h0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; run = 1'b1; ben = 1'b0; r = 1'b0; int_req = 1'b0;
      ir = 16'h1234; uinstruction = w(1'b1, 3'b000, 6'd0);
      tick(); tick();
      rst = 1'b0;
      check("rst_upc", upc, 18);
      check("rst_count", instr_count, 0);
      check("rst_halted", halted, 0);
      check("rst_fault", mem_fault, 0);

      tick();
      check("ird_upc", upc, 1);
      check("ird_count", instr_count, 1);

      uinstruction = w(1'b0, 3'b010, 6'd0); ben = 1'b1;
      tick(); check("ben1_upc", upc, 4);
      ben = 1'b0;
      tick(); check("ben0_upc", upc, 0);
      check("count_hold", instr_count, 1);

      uinstruction = w(1'b0, 3'b011, 6'd8); ir = 16'h0800;
      tick(); check("addr_upc", upc, 9);
      uinstruction = w(1'b0, 3'b101, 6'd16); int_req = 1'b1;
      tick(); check("int_upc", upc, 24);
      uinstruction = w(1'b0, 3'b111, 6'd5); ben = 1'b1; r = 1'b1;
      tick(); check("reserved_upc", upc, 5);
      uinstruction = w(1'b0, 3'b000, 6'd42); ben = 1'b0; r = 1'b0; int_req = 1'b0;
      tick(); check("jump_upc", upc, 42);

      uinstruction = w(1'b0, 3'b000, 6'd33);
      tick(); check("pre_stall_upc", upc, 33);
      uinstruction = w(1'b0, 3'b001, 6'd33);
      for (int i = 0; i < STALL_N; i++) begin
         tick(); check("stall_upc", upc, 33);
      end
      r = 1'b1;
      tick(); check("ready_upc", upc, 35);
      check("ready_fault", mem_fault, 0);
      r = 1'b0;

      uinstruction = w(1'b0, 3'b000, 6'd10); run = 1'b0;
      tick(); check("mid_upc", upc, 10);
      check("mid_halted", halted, 0);
      uinstruction = w(1'b0, 3'b000, 6'd18);
      tick(); check("park_upc", upc, 18);
      check("park_halted", halted, 1);
      uinstruction = w(1'b1, 3'b000, 6'd5); ir = 16'h5000;
      tick(); check("held_upc", upc, 18);
      check("held_halted", halted, 1);
      check("held_count", instr_count, 1);
      run = 1'b1;
      tick(); check("resume_halted", halted, 0);
      check("resume_upc", upc, 18);
      tick(); check("advance_upc", upc, 5);
      check("advance_count", instr_count, 2);

      uinstruction = w(1'b0, 3'b001, 6'd33); r = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         tick(); check("to_stall_upc", upc, 33);
      end
      tick(); check("to_fault_upc", upc, 63);
      check("to_fault_flag", mem_fault, 1);
      uinstruction = w(1'b0, 3'b000, 6'd7);
      tick(); check("to_after_upc", upc, 7);
      check("to_sticky", mem_fault, 1);
`else
      for (int i = 0; i < 10; i++) begin
         tick(); check("long_stall_upc", upc, 33);
         check("long_stall_fault", mem_fault, 0);
      end
`endif

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rerst_upc", upc, 18);
      check("rerst_count", instr_count, 0);
      check("rerst_fault", mem_fault, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
